noc_vc_channel_buffer: RTL and testbench

- Parametrised inter-router link stage that replaces the bare router-to-router wire in multi-router chains.
- Accepts flits on a packed channel, stores them in per-virtual-channel (VC) FIFOs, and forwards one flit per cycle downstream under credit-based flow control.
- Returns credits upstream one per VC.
- Raises a sticky ERROR on any protocol violation.

---
 rtl/noc_vc_channel_buffer.sv | 153 +++++++++++++++
 tb/tb_noc_vc_channel_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_channel_buffer.sv
// Per-VC buffered link stage with round-robin egress, credit flow control and a sticky error flag.
// Optional even-parity check on ingress flits when NOC_VC_BUF_PARITY_EN is defined.
module noc_vc_channel_buffer #(
  parameter int unsigned FLIT_W       = 68,
  parameter int unsigned NUM_VC       = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DOWN_CREDITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] CHANNEL_IN_IP,
  input  logic [NUM_VC-1:0] FLOW_CTRL_IN_OP,
  output logic [FLIT_W-1:0] CHANNEL_OUT_OP,
  output logic [NUM_VC-1:0] FLOW_CTRL_OUT_IP,
  output logic              ERROR
);

  localparam int unsigned VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned DATA_W = FLIT_W - 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W  = $clog2(DOWN_CREDITS + 1);

  // Storage holds everything except the valid bit, which is regenerated on egress.
  logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];

  logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0] count_q  [NUM_VC];
  logic [CNT_W-1:0] count_d  [NUM_VC];
  logic [CRD_W-1:0] credit_q [NUM_VC];
  logic [CRD_W-1:0] credit_d [NUM_VC];

  logic [VC_W-1:0]   rr_q, rr_d;
  logic [FLIT_W-1:0] chan_q, chan_d;
  logic [NUM_VC-1:0] fc_q, fc_d;
  logic              err_q, err_d;

  logic              in_valid, vc_ok, par_ok, in_err;
  logic [VC_W-1:0]   in_vc;
  logic [NUM_VC-1:0] wr_en, rd_en, elig, ovf, crd_err;
  logic              gnt_vld;
  logic [VC_W-1:0]   gnt_idx;
  int unsigned       idx;

  // Ingress decode: drop and flag bad VC ids, parity errors and writes to a full FIFO.
  always_comb begin
    in_valid = CHANNEL_IN_IP[0];
    in_vc    = CHANNEL_IN_IP[VC_W:1];
    vc_ok    = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (in_vc == VC_W'(v)) vc_ok = 1'b1;
    end
`ifdef NOC_VC_BUF_PARITY_EN
    par_ok = ~^CHANNEL_IN_IP[FLIT_W-1:1];
`else
    par_ok = 1'b1;
`endif
    in_err = in_valid & (~vc_ok | ~par_ok);
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      wr_en[v] = in_valid & vc_ok & par_ok & (in_vc == VC_W'(v)) &
                 (count_q[v] != CNT_W'(DEPTH));
      ovf[v]   = in_valid & vc_ok & par_ok & (in_vc == VC_W'(v)) &
                 (count_q[v] == CNT_W'(DEPTH));
    end
  end

  // Round-robin arbitration starting at rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      elig[v] = (count_q[v] != '0) && (credit_q[v] != '0);
    end
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      idx = (32'(rr_q) + i) % NUM_VC;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = VC_W'(idx);
      end
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      rd_en[v] = gnt_vld && (gnt_idx == VC_W'(v));
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_en[v] ? wr_ptr_q[v] + PTR_W'(1) : wr_ptr_q[v];
      rd_ptr_d[v] = rd_en[v] ? rd_ptr_q[v] + PTR_W'(1) : rd_ptr_q[v];
      count_d[v]  = count_q[v] + CNT_W'(wr_en[v]) - CNT_W'(rd_en[v]);
      credit_d[v] = credit_q[v];
      crd_err[v]  = 1'b0;
      unique case ({FLOW_CTRL_IN_OP[v], rd_en[v]})
        2'b10: begin
          if (credit_q[v] == CRD_W'(DOWN_CREDITS)) crd_err[v] = 1'b1;
          else credit_d[v] = credit_q[v] + CRD_W'(1);
        end
        2'b01:   credit_d[v] = credit_q[v] - CRD_W'(1);
        default: credit_d[v] = credit_q[v];
      endcase
    end
    if (gnt_vld) begin
      rr_d   = (gnt_idx == VC_W'(NUM_VC - 1)) ? '0 : gnt_idx + VC_W'(1);
      chan_d = {mem_q[gnt_idx][rd_ptr_q[gnt_idx]], 1'b1};
    end else begin
      rr_d   = rr_q;
      chan_d = '0;
    end
    fc_d  = rd_en;
    err_d = err_q | in_err | (|ovf) | (|crd_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        credit_q[v] <= CRD_W'(DOWN_CREDITS);
      end
      rr_q   <= '0;
      chan_q <= '0;
      fc_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
        credit_q[v] <= credit_d[v];
      end
      rr_q   <= rr_d;
      chan_q <= chan_d;
      fc_q   <= fc_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= CHANNEL_IN_IP[FLIT_W-1:1];
    end
  end

  assign CHANNEL_OUT_OP   = chan_q;
  assign FLOW_CTRL_OUT_IP = fc_q;
  assign ERROR            = err_q;

endmodule

// File: tb/tb_noc_vc_channel_buffer.sv
// Directed plus randomized bench for noc_vc_channel_buffer against a queue-based reference model.
module tb_noc_vc_channel_buffer;

  localparam int unsigned FLIT_W       = 68;
  localparam int unsigned NUM_VC       = 2;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned DOWN_CREDITS = 4;
  localparam int unsigned VC_W         = 1;
  localparam int unsigned PAY_W        = FLIT_W - 1 - VC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [FLIT_W-1:0] CHANNEL_IN_IP = '0;
  logic [NUM_VC-1:0] FLOW_CTRL_IN_OP = '0;
  logic [FLIT_W-1:0] CHANNEL_OUT_OP;
  logic [NUM_VC-1:0] FLOW_CTRL_OUT_IP;
  logic              ERROR;

  noc_vc_channel_buffer #(
    .FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .DOWN_CREDITS(DOWN_CREDITS)
  ) dut (
    .clk(clk), .reset(reset), .CHANNEL_IN_IP(CHANNEL_IN_IP), .FLOW_CTRL_IN_OP(FLOW_CTRL_IN_OP),
    .CHANNEL_OUT_OP(CHANNEL_OUT_OP), .FLOW_CTRL_OUT_IP(FLOW_CTRL_OUT_IP), .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;

  // Reference model: one flit queue per VC, integer credit counters.
  logic [FLIT_W-1:0] q [NUM_VC][$];
  int                cred [NUM_VC];
  int                rr;
  bit                merr;
  logic [FLIT_W-1:0] exp_chan;
  logic [NUM_VC-1:0] exp_fc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input int vc, input logic [PAY_W-1:0] pay);
    logic [FLIT_W-1:0] f;
    f = {pay, VC_W'(vc), 1'b1};
`ifdef NOC_VC_BUF_PARITY_EN
    f[FLIT_W-1] = ^f[FLIT_W-2:1];
`endif
    return f;
  endfunction

  function automatic bit parity_ok(input logic [FLIT_W-1:0] f);
`ifdef NOC_VC_BUF_PARITY_EN
    return (^f[FLIT_W-1:1]) == 1'b0;
`else
    return f[0] | 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      q[v].delete();
      cred[v] = DOWN_CREDITS;
    end
    rr = 0;
    merr = 1'b0;
    exp_chan = '0;
    exp_fc = '0;
  endtask

  task automatic model_cycle(input logic [FLIT_W-1:0] fin, input logic [NUM_VC-1:0] fcin);
    int g, wv;
    bit wr;
    g = -1;
    wr = 1'b0;
    wv = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      int v;
      v = (rr + i) % NUM_VC;
      if (g < 0 && q[v].size() > 0 && cred[v] > 0) g = v;
    end
    if (fin[0]) begin
      wv = int'(fin[VC_W:1]);
      if (wv >= NUM_VC || !parity_ok(fin) || q[wv].size() == DEPTH) merr = 1'b1;
      else wr = 1'b1;
    end
    exp_chan = '0;
    exp_fc = '0;
    if (g >= 0) begin
      exp_chan = q[g].pop_front();
      exp_fc[g] = 1'b1;
      rr = (g + 1) % NUM_VC;
    end
    if (wr) q[wv].push_back(fin);
    for (int v = 0; v < NUM_VC; v++) begin
      if (fcin[v] && g != v) begin
        if (cred[v] == DOWN_CREDITS) merr = 1'b1;
        else cred[v]++;
      end else if (!fcin[v] && g == v) begin
        cred[v]--;
      end
    end
  endtask

  task automatic step(input logic [FLIT_W-1:0] fin, input logic [NUM_VC-1:0] fcin);
    CHANNEL_IN_IP = fin;
    FLOW_CTRL_IN_OP = fcin;
    model_cycle(fin, fcin);
    @(posedge clk);
    #1;
    check("chan", CHANNEL_OUT_OP, exp_chan);
    check("fc_out", FLOW_CTRL_OUT_IP, exp_fc);
    check("error", ERROR, merr);
    if (CHANNEL_OUT_OP[0]) n_valid++;
  endtask

  // Asserts reset away from the clock edge and checks outputs clear without waiting for an edge.
  task automatic do_reset();
    #4;
    reset = 1'b1;
    CHANNEL_IN_IP = '0;
    FLOW_CTRL_IN_OP = '0;
    model_reset();
    #1;
    check("rst_chan", CHANNEL_OUT_OP, '0);
    check("rst_fc", FLOW_CTRL_OUT_IP, '0);
    check("rst_err", ERROR, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [PAY_W-1:0] rnd_pay();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PAY_W-1:0];
  endfunction

  initial begin
    logic [FLIT_W-1:0] f;
    logic [NUM_VC-1:0] fc;
    int vc;

    do_reset();
    for (int i = 0; i < 10; i++) step('0, '0);

    // Single flit, one-cycle latency
    step(mk_flit(0, PAY_W'('hA5)), '0);
    step('0, '0);
    check("a5_out", CHANNEL_OUT_OP, mk_flit(0, PAY_W'('hA5)));
    check("a5_fc", FLOW_CTRL_OUT_IP, 2'b01);

    // Interleaved load on both VCs gives alternating egress
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step((i < 8) ? mk_flit(i % 2, PAY_W'(i)) : '0, '0);
      if (i >= 1) check("alt_vc", CHANNEL_OUT_OP[VC_W:0], {VC_W'((i - 1) % 2), 1'b1});
    end

    // Credit exhaustion on VC1, then a single returned credit
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 10; i++) step((i < 6) ? mk_flit(1, PAY_W'(100 + i)) : '0, '0);
    check("stall_sent", n_valid, 4);
    n_valid = 0;
    step('0, 2'b10);
    for (int i = 0; i < 4; i++) step('0, '0);
    check("one_more", n_valid, 1);
    check("stall_err", ERROR, 1'b0);

    // Overflow VC0 while stalled on credits
    do_reset();
    for (int i = 0; i < 6; i++) step((i < 4) ? mk_flit(0, PAY_W'(i)) : '0, '0);
    for (int i = 0; i < 4; i++) step(mk_flit(0, PAY_W'(20 + i)), '0);
    check("full_err0", ERROR, 1'b0);
    step(mk_flit(0, PAY_W'(99)), '0);
    check("ovf_err", ERROR, 1'b1);
    for (int i = 0; i < 8; i++) step('0, (i < 4) ? 2'b01 : 2'b00);
    check("ovf_sticky", ERROR, 1'b1);

    // Credit return while already at the maximum
    do_reset();
    step('0, 2'b01);
    check("crd_sat_err", ERROR, 1'b1);

    // Corrupted top bit on a VC1 flit
    do_reset();
    f = mk_flit(1, PAY_W'('h3C));
    f[FLIT_W-1] = ~f[FLIT_W-1];
    step(f, '0);
    step('0, '0);
`ifdef NOC_VC_BUF_PARITY_EN
    check("par_drop", CHANNEL_OUT_OP, '0);
    check("par_err", ERROR, 1'b1);
`else
    check("par_fwd", CHANNEL_OUT_OP, f);
    check("par_noerr", ERROR, 1'b0);
`endif

    // Reset mid-stream with three VC0 flits buffered and a VC1 flit on the output
    do_reset();
    for (int i = 0; i < 7; i++) step(mk_flit(0, PAY_W'(40 + i)), '0);
    step(mk_flit(1, PAY_W'(77)), '0);
    step('0, '0);
    check("pre_rst_valid", CHANNEL_OUT_OP[0], 1'b1);
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 8; i++) step('0, (i % 2 == 0) ? 2'b00 : 2'b00);
    check("no_ghost", n_valid, 0);

    // Random traffic that stays within the protocol
    do_reset();
    for (int i = 0; i < 400; i++) begin
      vc = int'($urandom_range(0, NUM_VC - 1));
      f = '0;
      if (($urandom % 3) != 0 && q[vc].size() < DEPTH) f = mk_flit(vc, rnd_pay());
      for (int v = 0; v < NUM_VC; v++) fc[v] = ($urandom % 2 == 1) && (cred[v] < DOWN_CREDITS);
      step(f, fc);
    end
    check("rand_clean_err", ERROR, 1'b0);

    // Random traffic with protocol violations allowed
    do_reset();
    for (int i = 0; i < 300; i++) begin
      vc = int'($urandom_range(0, NUM_VC - 1));
      f = ($urandom % 4 != 0) ? mk_flit(vc, rnd_pay()) : '0;
      if ($urandom % 16 == 0) f[FLIT_W-1] = ~f[FLIT_W-1];
      fc = NUM_VC'($urandom);
      step(f, fc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
